// File: rtl/simple_ram_responder.sv
// Word RAM for the SimpleCPU port with a streaming program loader that fills from address 0 while holding the CPU.
// Optional build macro RAM_RDW_FORWARD_EN: CPU read+write to the same address returns the new data (write-first).
module simple_ram_responder #(
  parameter int SIZE = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [SIZE-1:0] addr_toRAM,
  input  logic [31:0]     data_toRAM,
  output logic [31:0]     data_fromRAM,
  input  logic            ld_start,
  input  logic [SIZE:0]   ld_len,
  input  logic            ld_valid,
  input  logic [31:0]     ld_data,
  output logic            ld_ready,
  output logic [SIZE-1:0] ld_addr,
  output logic            cpu_hold,
  output logic            ld_done
);

  localparam int unsigned     DEPTH    = 1 << SIZE;
  localparam logic [SIZE:0]   DEPTH_W  = (SIZE+1)'(DEPTH);
  localparam logic [SIZE:0]   REM_ONE  = (SIZE+1)'(1);
  localparam logic [SIZE-1:0] ADDR_ONE = SIZE'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_ld_addr;
  logic [SIZE:0]   r_remaining;
  logic [31:0]     r_rdata;
  logic            r_ld_ready;
  logic            r_cpu_hold;
  logic            r_ld_done;
  logic [31:0]     r_mem [0:DEPTH-1];

  state_t          w_state_nxt;
  logic [SIZE-1:0] w_addr_nxt;
  logic [SIZE:0]   w_rem_nxt;
  logic [SIZE:0]   w_len_eff;
  logic            w_cpu_we;
  logic            w_ld_we;
  logic            w_mem_we;
  logic [SIZE-1:0] w_mem_waddr;
  logic [31:0]     w_mem_wdata;
  logic [31:0]     w_rdata_nxt;

  // Clamp the requested length so a load never wraps the fill address.
  always_comb begin
    if (ld_len > DEPTH_W) begin
      w_len_eff = DEPTH_W;
    end else begin
      w_len_eff = ld_len;
    end
  end

  // Next-state logic for the loader FSM and its fill counters.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_ld_addr;
    w_rem_nxt   = r_remaining;
    w_cpu_we    = 1'b0;
    w_ld_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cpu_we = wrEn;
        if (ld_start) begin
          if (w_len_eff != {(SIZE+1){1'b0}}) begin
            w_state_nxt = ST_LOAD;
            w_addr_nxt  = {SIZE{1'b0}};
            w_rem_nxt   = w_len_eff;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          w_ld_we    = 1'b1;
          w_addr_nxt = r_ld_addr + ADDR_ONE;
          w_rem_nxt  = r_remaining - REM_ONE;
          if (r_remaining == REM_ONE) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The loader and CPU never write together: the CPU port is only live in IDLE.
  always_comb begin
    w_mem_we = rst & (w_cpu_we | w_ld_we);
    if (w_ld_we) begin
      w_mem_waddr = r_ld_addr;
      w_mem_wdata = ld_data;
    end else begin
      w_mem_waddr = addr_toRAM;
      w_mem_wdata = data_toRAM;
    end
  end

  // CPU read data: live RAM in IDLE, forced to zero while loading.
  always_comb begin
    if (r_state == ST_IDLE) begin
`ifdef RAM_RDW_FORWARD_EN
      if (wrEn) begin
        w_rdata_nxt = data_toRAM;
      end else begin
        w_rdata_nxt = r_mem[addr_toRAM];
      end
`else
      w_rdata_nxt = r_mem[addr_toRAM];
`endif
    end else begin
      w_rdata_nxt = 32'd0;
    end
  end

  // RAM array: contents survive reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // State, counters and state-decoded outputs registered together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ld_addr   <= {SIZE{1'b0}};
      r_remaining <= {(SIZE+1){1'b0}};
      r_rdata     <= 32'd0;
      r_ld_ready  <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_ld_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ld_addr   <= w_addr_nxt;
      r_remaining <= w_rem_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ld_ready  <= (w_state_nxt == ST_LOAD);
      r_cpu_hold  <= (w_state_nxt != ST_IDLE);
      r_ld_done   <= (w_state_nxt == ST_DONE);
    end
  end

  assign data_fromRAM = r_rdata;
  assign ld_ready     = r_ld_ready;
  assign ld_addr      = r_ld_addr;
  assign cpu_hold     = r_cpu_hold;
  assign ld_done      = r_ld_done;

endmodule

// File: tb/tb_simple_ram_responder.sv
// Self-checking bench for simple_ram_responder: directed scenarios plus random traffic against a behavioural model.
module tb_simple_ram_responder;

  localparam int SIZE  = 10;
  localparam int DEPTH = 1 << SIZE;
`ifdef RAM_RDW_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wrEn;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM;
  logic            ld_start;
  logic [SIZE:0]   ld_len;
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic            ld_ready;
  logic [SIZE-1:0] ld_addr;
  logic            cpu_hold;
  logic            ld_done;

  simple_ram_responder #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM),
    .data_fromRAM(data_fromRAM), .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_addr(ld_addr), .cpu_hold(cpu_hold), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: what the RAM holds, whether a load is in flight and how many words it still wants.
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          m_mode, m_fill, m_left;
  logic [31:0] m_rdata;
  bit          m_rdata_known;

  task automatic model_step();
    int n;
    if (!rst) begin
      m_rdata = 32'd0; m_rdata_known = 1'b1;
      m_mode = M_IDLE; m_fill = 0; m_left = 0;
    end else if (m_mode == M_IDLE) begin
      if (wrEn && FWD) begin
        m_rdata = data_toRAM; m_rdata_known = 1'b1;
      end else begin
        m_rdata = m_mem[addr_toRAM]; m_rdata_known = m_known[addr_toRAM];
      end
      if (wrEn) begin
        m_mem[addr_toRAM] = data_toRAM; m_known[addr_toRAM] = 1'b1;
      end
      if (ld_start) begin
        n = (int'(ld_len) > DEPTH) ? DEPTH : int'(ld_len);
        if (n == 0) m_mode = M_DONE;
        else begin m_mode = M_LOAD; m_fill = 0; m_left = n; end
      end
    end else if (m_mode == M_LOAD) begin
      m_rdata = 32'd0; m_rdata_known = 1'b1;
      if (ld_valid) begin
        m_mem[m_fill] = ld_data; m_known[m_fill] = 1'b1;
        m_fill = (m_fill + 1) % DEPTH;
        m_left--;
        if (m_left == 0) m_mode = M_DONE;
      end
    end else begin
      m_rdata = 32'd0; m_rdata_known = 1'b1;
      m_mode = M_IDLE;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (m_rdata_known) check_eq("rdata", data_fromRAM, m_rdata);
    check_eq("ld_ready", {31'd0, ld_ready}, {31'd0, m_mode == M_LOAD});
    check_eq("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_mode != M_IDLE});
    check_eq("ld_done",  {31'd0, ld_done},  {31'd0, m_mode == M_DONE});
    check_eq("ld_addr",  {22'd0, ld_addr},  32'(m_fill));
  endtask

  task automatic idle_inputs();
    rst = 1'b1; wrEn = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d);
    wrEn = 1'b1; addr_toRAM = SIZE'(a); data_toRAM = d;
    tick();
    wrEn = 1'b0;
  endtask

  task automatic cpu_read(input int a);
    wrEn = 1'b0; addr_toRAM = SIZE'(a);
    tick();
  endtask

  task automatic start_load(input int len);
    ld_start = 1'b1; ld_len = (SIZE+1)'(len);
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_mode = M_IDLE; m_fill = 0; m_left = 0; m_rdata = 32'd0; m_rdata_known = 1'b0;
    addr_toRAM = '0; data_toRAM = 32'd0; ld_len = '0; ld_data = 32'd0;
    idle_inputs();

    // Reset with noisy inputs: outputs zero.
    rst = 1'b0; wrEn = 1'b1; ld_valid = 1'b1; addr_toRAM = SIZE'(3); data_toRAM = 32'hDEAD_BEEF;
    tick(); tick();
    check_eq("rst_rdata", data_fromRAM, 32'd0);
    idle_inputs();
    cpu_write(3, 32'hA5A5_0003);
    // Reset must not disturb RAM even with wrEn and ld_valid asserted.
    rst = 1'b0; wrEn = 1'b1; ld_valid = 1'b1; ld_start = 1'b1; ld_len = (SIZE+1)'(4);
    addr_toRAM = SIZE'(3); data_toRAM = 32'h0BAD_0BAD;
    tick(); tick();
    idle_inputs();
    cpu_read(3);
    check_eq("rst_ram_kept", data_fromRAM, 32'hA5A5_0003);

    // Write then read back with one-cycle latency.
    cpu_write(5, 32'h1234_5678);
    cpu_read(5);
    check_eq("rd_after_wr", data_fromRAM, 32'h1234_5678);

    // Read-during-write on the same address.
    cpu_write(7, 32'hAAAA_0000);
    cpu_write(7, 32'h0000_5555);
    check_eq("rdw", data_fromRAM, FWD ? 32'h0000_5555 : 32'hAAAA_0000);
    cpu_read(7);
    check_eq("rdw_after", data_fromRAM, 32'h0000_5555);

    // Four-word load with gaps; CPU writes during the load must be dropped.
    cpu_write(20, 32'h00C0_FFEE);
    start_load(4);
    begin
      bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int k = 0;
      wrEn = 1'b1; addr_toRAM = SIZE'(20); data_toRAM = 32'hBAD0_0020;
      for (int i = 0; i < 6; i++) begin
        ld_valid = pat[i]; ld_data = 32'(10 + k);
        if (pat[i]) k++;
        tick();
      end
      check_eq("load4_done", {31'd0, ld_done}, 32'd1);
      ld_valid = 1'b0;
      tick();
      wrEn = 1'b0;
      check_eq("load4_idle", {31'd0, cpu_hold}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_read(i);
      check_eq("load4_mem", data_fromRAM, 32'(10 + i));
    end
    cpu_read(20);
    check_eq("load4_cpu_blocked", data_fromRAM, 32'h00C0_FFEE);

    // Zero-length load goes straight to DONE.
    start_load(0);
    check_eq("len0_done", {31'd0, ld_done}, 32'd1);
    tick();

    // Oversized load: exactly DEPTH transfers, fill address wraps to 0.
    start_load(DEPTH + 5);
    ld_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_data = $urandom;
      tick();
    end
    check_eq("big_done", {31'd0, ld_done}, 32'd1);
    check_eq("big_addr", {22'd0, ld_addr}, 32'd0);
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 16; i++) cpu_read($urandom_range(0, DEPTH - 1));

    // Reset in the middle of a load keeps the words already written.
    for (int i = 0; i < 4; i++) cpu_write(i, 32'hD000_0000 + 32'(i));
    start_load(4);
    ld_valid = 1'b1; ld_data = 32'hE000_0000; tick();
    ld_data = 32'hE000_0001; tick();
    ld_valid = 1'b0; rst = 1'b0;
    tick();
    check_eq("abort_hold", {31'd0, cpu_hold}, 32'd0);
    check_eq("abort_nodone", {31'd0, ld_done}, 32'd0);
    idle_inputs();
    for (int i = 0; i < 4; i++) cpu_read(i);
    check_eq("abort_mem3", data_fromRAM, 32'hD000_0003);

    // Random traffic; addresses confined to a small window to create hits.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 99) != 0);
      wrEn       = $urandom_range(0, 1) == 1;
      addr_toRAM = SIZE'($urandom_range(0, 15));
      data_toRAM = $urandom;
      ld_start   = ($urandom_range(0, 15) == 0);
      ld_len     = ($urandom_range(0, 7) == 0) ? (SIZE+1)'($urandom_range(0, 2 * DEPTH - 1))
                                                : (SIZE+1)'($urandom_range(0, 9));
      ld_valid   = $urandom_range(0, 2) != 0;
      ld_data    = $urandom;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) cpu_read(i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
